// File: rtl/simd_pkg.sv
// ============================================================================
// Module      : simd_pkg
// Description : Shared types, constants and lane-geometry helpers for the
//               SIMD add/subtract pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simd_pkg;

    localparam int DEF_MIN_LANE_W = 8;

    typedef enum logic [1:0] {
        LANE_X1 = 2'b00,
        LANE_X2 = 2'b01,
        LANE_X4 = 2'b10
    } lane_mode_e;

    typedef struct packed {
        lane_mode_e lane_mode;
        logic       sub;
        logic       is_signed;
        logic       sat;
    } simd_ctrl_t;

    // Encoding 11 is folded onto the widest lane.
    function automatic lane_mode_e norm_mode(logic [1:0] m);
        return (m == 2'b11) ? LANE_X4 : lane_mode_e'(m);
    endfunction

    function automatic logic slice_is_start(int i, lane_mode_e m);
        return ((i & ((1 << int'(m)) - 1)) == 0);
    endfunction

    function automatic logic slice_is_top(int i, lane_mode_e m);
        return ((i & ((1 << int'(m)) - 1)) == ((1 << int'(m)) - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/simd_addsub_pipe_if.sv
// ============================================================================
// Module      : simd_addsub_pipe_if
// Description : Operand/result handshake bundle of the SIMD add/sub unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simd_addsub_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int MIN_LANE_W = 8
);
    localparam int NSLICE = DATA_W / MIN_LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [1:0]        in_lane_mode;
    logic              in_sub;
    logic              in_signed;
    logic              in_sat;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [NSLICE-1:0] out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_lane_mode, in_sub, in_signed, in_sat, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_lane_mode, in_sub, in_signed, in_sat, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

endinterface

`default_nettype wire

// File: rtl/simd_slice_addsub.sv
// ============================================================================
// Module      : simd_slice_addsub
// Description : One minimum-width slice of the SIMD adder: carry-chain link
//               with lane-start carry injection and MSB signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simd_slice_addsub #(
    parameter int W = 8
) (
    input  wire logic [W-1:0] a,
    input  wire logic [W-1:0] b,
    input  wire logic         sub,
    input  wire logic         cin,
    input  wire logic         is_lane_start,
    output logic      [W-1:0] sum,
    output logic              cout,
    output logic              sovf
);

    logic [W-1:0] w_bx;
    logic         w_cin;

    assign w_bx  = b ^ {W{sub}};
    assign w_cin = is_lane_start ? sub : cin;

    assign {cout, sum} = {1'b0, a} + {1'b0, w_bx} + {{W{1'b0}}, w_cin};

    // Only meaningful when this slice is the top of its lane.
    assign sovf = (a[W-1] == w_bx[W-1]) && (sum[W-1] != a[W-1]);

endmodule

`default_nettype wire

// File: rtl/simd_addsub_pipe.sv
// ============================================================================
// Module      : simd_addsub_pipe
// Description : Two-stage SIMD add/sub with per-transaction lane width,
//               per-lane overflow and optional saturation (SIMD_SAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simd_addsub_pipe
    import simd_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MIN_LANE_W = DEF_MIN_LANE_W
) (
    input wire logic          clk,
    input wire logic          rst_n,
    simd_addsub_pipe_if.slave bus
);

    localparam int NSLICE = DATA_W / MIN_LANE_W;

    if (DATA_W % (4 * MIN_LANE_W) != 0) begin : g_bad_cfg
        $error("simd_addsub_pipe: DATA_W must be a multiple of 4*MIN_LANE_W");
    end

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    simd_ctrl_t        r_s1_ctrl;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [NSLICE-1:0] r_s2_ovf;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_res;
    logic [NSLICE-1:0] w_cout;
    logic [NSLICE-1:0] w_cin;
    logic [NSLICE-1:0] w_sovf;
    logic [NSLICE-1:0] w_ovf;

    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_adv && rst_n;

    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_ovf   = r_s2_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_ctrl  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_ovf   <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_a              <= bus.in_a;
                    r_s1_b              <= bus.in_b;
                    r_s1_ctrl.lane_mode <= norm_mode(bus.in_lane_mode);
                    r_s1_ctrl.sub       <= bus.in_sub;
                    r_s1_ctrl.is_signed <= bus.in_signed;
`ifdef SIMD_SAT_EN
                    r_s1_ctrl.sat       <= bus.in_sat;
`else
                    r_s1_ctrl.sat       <= 1'b0;
`endif
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_res;
                    r_s2_ovf  <= w_ovf;
                end
            end
        end
    end

    // Slice i takes the carry from slice i-1 unless it begins a lane.
    assign w_cin = {w_cout[NSLICE-2:0], 1'b0};

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        simd_slice_addsub #(
            .W (MIN_LANE_W)
        ) u_slice (
            .a             (r_s1_a[gi*MIN_LANE_W +: MIN_LANE_W]),
            .b             (r_s1_b[gi*MIN_LANE_W +: MIN_LANE_W]),
            .sub           (r_s1_ctrl.sub),
            .cin           (w_cin[gi]),
            .is_lane_start (slice_is_start(gi, r_s1_ctrl.lane_mode)),
            .sum           (w_sum[gi*MIN_LANE_W +: MIN_LANE_W]),
            .cout          (w_cout[gi]),
            .sovf          (w_sovf[gi])
        );
    end

    always_comb begin
        w_ovf = '0;
        for (int i = 0; i < NSLICE; i++) begin
            w_ovf[i] = slice_is_top(i, r_s1_ctrl.lane_mode) &&
                       (r_s1_ctrl.is_signed ? w_sovf[i] : (w_cout[i] ^ r_s1_ctrl.sub));
        end
    end

`ifdef SIMD_SAT_EN
    always_comb begin
        int                    t;
        logic                  fill;
        logic [MIN_LANE_W-1:0] slc;
        w_res = w_sum;
        t     = 0;
        fill  = 1'b0;
        slc   = '0;
        for (int i = 0; i < NSLICE; i++) begin
            t = i | ((1 << int'(r_s1_ctrl.lane_mode)) - 1);
            if (r_s1_ctrl.sat && w_ovf[t]) begin
                // Signed: A's sign picks the rail; unsigned: add clamps high, sub low.
                fill = r_s1_ctrl.is_signed ? ~r_s1_a[t*MIN_LANE_W + MIN_LANE_W - 1]
                                           : ~r_s1_ctrl.sub;
                slc  = {MIN_LANE_W{fill}};
                if (r_s1_ctrl.is_signed && (i == t)) begin
                    slc[MIN_LANE_W-1] = ~fill;
                end
                w_res[i*MIN_LANE_W +: MIN_LANE_W] = slc;
            end
        end
    end
`else
    logic w_unused_sat;
    assign w_unused_sat = r_s1_ctrl.sat;
    assign w_res        = w_sum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_simd_addsub_pipe.sv
// ============================================================================
// Module      : tb_simd_addsub_pipe
// Description : Self-checking bench for simd_addsub_pipe: directed vectors,
//               stall/reset scenarios and randomized traffic vs. lane model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simd_addsub_pipe;

`ifdef SIMD_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  o;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   recv;
    exp_t q[$];

    simd_addsub_pipe_if #(.DATA_W(32), .MIN_LANE_W(8)) bus ();

    simd_addsub_pipe #(.DATA_W(32), .MIN_LANE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane-by-lane integer arithmetic with range checks.
    function automatic exp_t ref_model(logic [31:0] a, logic [31:0] b, logic [1:0] m,
                                       logic sub, logic sgn, logic sat);
        exp_t   e;
        int     lw;
        longint mask, av, bv, r, lo, hi;
        logic   ovf;
        e    = '0;
        lw   = 8 << ((m == 2'b11) ? 2 : int'(m));
        mask = (longint'(1) << lw) - 1;
        for (int l = 0; l < 32 / lw; l++) begin
            av = longint'(a >> (l * lw)) & mask;
            bv = longint'(b >> (l * lw)) & mask;
            if (sgn) begin
                if (av > (mask >> 1)) av = av - (mask + 1);
                if (bv > (mask >> 1)) bv = bv - (mask + 1);
                lo = -((mask + 1) >> 1);
                hi = mask >> 1;
            end else begin
                lo = 0;
                hi = mask;
            end
            r   = sub ? av - bv : av + bv;
            ovf = (r < lo) || (r > hi);
            if (ovf && sat && c_sat_en) r = (r > hi) ? hi : lo;
            e.d = e.d | (32'(r & mask) << (l * lw));
            e.o[(l + 1) * (lw / 8) - 1] = ovf;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic [1:0] m,
                         logic sub, logic sgn, logic sat);
        bus.in_valid     = v;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_lane_mode = m;
        bus.in_sub       = sub;
        bus.in_signed    = sgn;
        bus.in_sat       = sat;
    endtask

    // Entered at posedge+1; one accept, then checks the 2-cycle latency.
    task automatic run_dir(string tag, logic [31:0] a, logic [31:0] b, logic [1:0] m,
                           logic sub, logic sgn, logic sat,
                           logic [31:0] exp_d, logic [3:0] exp_o);
        drive(1'b1, a, b, m, sub, sgn, sat);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early_valid"}, 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        chk({tag, "_data"}, 64'(bus.out_data), 64'(exp_d));
        chk({tag, "_ovf"}, 64'(bus.out_ovf), 64'(exp_o));
        @(posedge clk); #1;
    endtask

    // Called at negedge: retire a result and/or log an accepted transaction.
    task automatic sb_sample(string tag);
        exp_t e;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk({tag, "_spurious"}, 64'(bus.out_valid), 64'(0));
            end else begin
                e = q.pop_front();
                chk({tag, "_data"}, 64'(bus.out_data), 64'(e.d));
                chk({tag, "_ovf"}, 64'(bus.out_ovf), 64'(e.o));
            end
            recv++;
        end
        if (bus.in_valid && bus.in_ready) begin
            q.push_back(ref_model(bus.in_a, bus.in_b, bus.in_lane_mode,
                                  bus.in_sub, bus.in_signed, bus.in_sat));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8080_8080;
            3:       return 32'h7F7F_7F7F;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] ta [4];
        logic [31:0] tb_b [4];
        logic [1:0]  tm [4];
        logic [31:0] t0_d;
        int          idx;
        int          guard;
        exp_t        e0;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_ovf", 64'(bus.out_ovf), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        run_dir("t1_x1_add", 32'h01FF_7F80, 32'h0101_0101, 2'b00, 1'b0, 1'b0, 1'b0,
                32'h0200_8081, 4'b0100);
        run_dir("t2_x2_add", 32'h01FF_7F80, 32'h0101_0101, 2'b01, 1'b0, 1'b0, 1'b0,
                32'h0300_8081, 4'b0000);
        run_dir("t3_x1_ssub_sat", 32'h8080_7F00, 32'h01FF_FF01, 2'b00, 1'b1, 1'b1, 1'b1,
                c_sat_en ? 32'h8081_7FFF : 32'h7F81_80FF, 4'b1010);
        run_dir("t4_x4_add_sat", 32'hFFFF_FFF0, 32'h0000_0020, 2'b10, 1'b0, 1'b0, 1'b1,
                c_sat_en ? 32'hFFFF_FFFF : 32'h0000_0010, 4'b1000);
        run_dir("t4_x4_add_wrap", 32'hFFFF_FFF0, 32'h0000_0020, 2'b10, 1'b0, 1'b0, 1'b0,
                32'h0000_0010, 4'b1000);
        run_dir("t4_mode11_usub", 32'h0000_0001, 32'h0000_0002, 2'b11, 1'b1, 1'b0, 1'b1,
                c_sat_en ? 32'h0000_0000 : 32'hFFFF_FFFF, 4'b1000);

        // Back-to-back with a 3-cycle output stall after T0 arrives
        for (int i = 0; i < 4; i++) begin
            ta[i]   = $urandom();
            tb_b[i] = $urandom();
            tm[i]   = 2'($urandom_range(0, 3));
        end
        e0   = ref_model(ta[0], tb_b[0], tm[0], 1'b0, 1'b1, 1'b1);
        t0_d = e0.d;
        idx  = 0;
        recv = 0;
        for (int c = 0; c < 14; c++) begin
            drive(idx < 4, ta[idx & 3], tb_b[idx & 3], tm[idx & 3], 1'b0, 1'b1, 1'b1);
            bus.out_ready = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                chk("stall_valid", 64'(bus.out_valid), 64'(1));
                chk("stall_hold_data", 64'(bus.out_data), 64'(t0_d));
                chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
            end
            if (bus.in_valid && bus.in_ready) idx++;
            sb_sample("stall");
            @(posedge clk); #1;
        end
        chk("stall_recv_count", 64'(recv), 64'(4));
        chk("stall_queue_empty", 64'(q.size()), 64'(0));

        // Asynchronous reset with both stages occupied
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1234_5678, 32'h1111_1111, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'hAAAA_5555, 32'h0101_0101, 2'b01, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
        chk("pre_rst_full", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_data", 64'(bus.out_data), 64'(0));
        chk("mid_rst_ovf", 64'(bus.out_ovf), 64'(0));
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(bus.out_valid), 64'(0));
        run_dir("post_rst_txn", 32'h7F00_FF80, 32'h0100_0180, 2'b00, 1'b0, 1'b1, 1'b1,
                c_sat_en ? 32'h7F00_0080 : 32'h8000_0000, 4'b1001);

        // Randomized traffic with random back-pressure
        q.delete();
        recv = 0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
                  2'($urandom_range(0, 3)), 1'($urandom()), 1'($urandom()), 1'($urandom()));
            bus.out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            sb_sample("rand");
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            sb_sample("drain");
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'(0));
        @(negedge clk);
        chk("drain_idle_valid", 64'(bus.out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
